// File: rtl/re_pingpong_buffer.sv
// Multi-bank RE sample buffer feeding the IFFT: banks fill round-robin, drain in
// commit order, and every location is zeroed as it is read so unwritten REs come out as 0.

module re_pingpong_bank #(
  parameter int DEPTH = 2048,
  parameter int W     = 18
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     a_we,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [W-1:0]             a_data,
  input  logic                     b_en,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output logic [W-1:0]             b_data
);
  logic [W-1:0] mem [DEPTH];

  // Port B is read-then-clear; the two ports never target the same bank in one cycle.
  always_ff @(posedge CLK) begin
    if (a_we) mem[a_addr] <= a_data;
    if (b_en) mem[b_addr] <= '0;
  end

  always_ff @(posedge CLK) begin
    if (RST)       b_data <= '0;
    else if (b_en) b_data <= mem[b_addr];
  end
endmodule

module re_pingpong_buffer #(
  parameter int MEM_DEPTH        = 2048,
  parameter int IN_WIDTH         = 18,
  parameter int OUT_WIDTH        = 26,
  parameter int NUM_BANKS        = 2,
  parameter int WRITE_ADDR_SHIFT = 420
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [IN_WIDTH-1:0]            data_in,
  input  logic [$clog2(MEM_DEPTH)-1:0]   write_addr,
  input  logic                           write_enable,
  input  logic                           Sym_Done,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           data_out,
  output logic                           out_valid,
  output logic                           out_last,
  output logic                           overflow,
  output logic                           addr_drop,
  output logic [$clog2(NUM_BANKS):0]     banks_full
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = BW + 1;
  localparam logic [AW:0]   SHIFT_V = (AW+1)'(WRITE_ADDR_SHIFT);
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(MEM_DEPTH);
  localparam logic [CW-1:0] NB_V    = CW'(NUM_BANKS);

  typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_e;

  rd_state_e st_q, st_d;
  logic [BW-1:0] wr_bank, rd_bank, sel_bank, fetch_bank;
  logic [CW-1:0] full_cnt;
  logic [AW-1:0] rd_idx, fetch_idx, sweep_idx, a_addr;
  logic [AW:0]   wr_sum;
  logic [IN_WIDTH-1:0] a_data;
  logic [NUM_BANKS-1:0] a_we, b_en;
  logic [NUM_BANKS-1:0][IN_WIDTH-1:0] bank_q;
  logic signed [IN_WIDTH-1:0] q_s;
  logic sweeping, wr_active, accept_wr, in_range, mem_we, commit, lost, accept, rel, fetch;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS-1)) ? '0 : b + BW'(1);
  endfunction

  // The ring order means the next bank to fill is always wr_bank and the oldest FULL
  // bank is always rd_bank; a bank is FILLING whenever not every bank is FULL.
  assign wr_active = (full_cnt != NB_V);
  assign wr_sum    = {1'b0, write_addr} + SHIFT_V;
  assign in_range  = (wr_sum < DEPTH_V);
  // Writes that arrive while the post-reset sweep runs would be wiped by it, so they are dropped.
  assign accept_wr = write_enable && wr_active && !sweeping;
  assign mem_we    = accept_wr && in_range;
  assign commit    = Sym_Done && wr_active;
  assign lost      = (write_enable || Sym_Done) && !wr_active;
  assign accept    = out_valid && out_ready;
  assign rel       = (st_q == RD_STREAM) && accept && out_last;

  always_comb begin
    st_d       = st_q;
    fetch      = 1'b0;
    fetch_bank = rd_bank;
    fetch_idx  = '0;
    case (st_q)
      RD_IDLE:  if (full_cnt != '0 && !sweeping) st_d = RD_PRIME;
      RD_PRIME: begin
        fetch = 1'b1;
        st_d  = RD_STREAM;
      end
      RD_STREAM: if (accept) begin
        if (out_last) begin
          // Only chain into a bank that was already FULL; one committing now may still be taking its last write.
          if (full_cnt > CW'(1)) begin
            fetch      = 1'b1;
            fetch_bank = next_bank(rd_bank);
          end else begin
            st_d = RD_IDLE;
          end
        end else begin
          fetch     = 1'b1;
          fetch_idx = rd_idx;
        end
      end
      default: st_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) st_q <= RD_IDLE;
    else     st_q <= st_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_bank   <= '0;
      rd_bank   <= '0;
      sel_bank  <= '0;
      full_cnt  <= '0;
      sweeping  <= 1'b1;
      sweep_idx <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      addr_drop <= 1'b0;
    end else begin
      overflow  <= lost;
      addr_drop <= accept_wr && !in_range;
      full_cnt  <= full_cnt + CW'(commit) - CW'(rel);
      if (commit) wr_bank <= next_bank(wr_bank);
      if (rel)    rd_bank <= next_bank(rd_bank);
      if (sweeping) begin
        sweep_idx <= sweep_idx + AW'(1);
        if (sweep_idx == AW'(MEM_DEPTH-1)) sweeping <= 1'b0;
      end
      if (fetch) begin
        sel_bank  <= fetch_bank;
        out_valid <= 1'b1;
        out_last  <= (fetch_idx == AW'(MEM_DEPTH-1));
        rd_idx    <= fetch_idx + AW'(1);
      end else if (rel) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign a_addr = sweeping ? sweep_idx : wr_sum[AW-1:0];
  assign a_data = sweeping ? '0 : data_in;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign a_we[b] = !RST && (sweeping || (mem_we && wr_bank == BW'(b)));
    assign b_en[b] = !RST && fetch && (fetch_bank == BW'(b));
    re_pingpong_bank #(.DEPTH(MEM_DEPTH), .W(IN_WIDTH)) u_bank (
      .CLK    (CLK),
      .RST    (RST),
      .a_we   (a_we[b]),
      .a_addr (a_addr),
      .a_data (a_data),
      .b_en   (b_en[b]),
      .b_addr (fetch_idx),
      .b_data (bank_q[b])
    );
  end

  assign q_s        = bank_q[sel_bank];
  assign data_out   = OUT_WIDTH'(q_s);
  assign banks_full = full_cnt;
endmodule

// File: tb/tb_re_pingpong_buffer.sv
// Randomized bench for re_pingpong_buffer against a symbol-level model (per-symbol
// sample images queued in commit order) plus literal checks on known samples.

module tb_re_pingpong_buffer;
  localparam int MD = 2048, IW = 18, OW = 26, NB = 2, SH = 420;

  logic clk = 1'b0, rst = 1'b1;
  logic [IW-1:0] din = '0;
  logic [10:0] waddr = '0;
  logic we = 1'b0, sd = 1'b0, ready = 1'b0;
  logic [OW-1:0] data_out;
  logic out_valid, out_last, overflow, addr_drop;
  logic [1:0] banks_full;

  always #5 clk = ~clk;

  re_pingpong_buffer #(.MEM_DEPTH(MD), .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_BANKS(NB),
                       .WRITE_ADDR_SHIFT(SH)) dut (
    .CLK(clk), .RST(rst), .data_in(din), .write_addr(waddr), .write_enable(we),
    .Sym_Done(sd), .out_ready(ready), .data_out(data_out), .out_valid(out_valid),
    .out_last(out_last), .overflow(overflow), .addr_drop(addr_drop), .banks_full(banks_full));

  int checks = 0, errors = 0;
  int exp_q[$];
  logic [IW-1:0] cur [MD];
  logic [OW-1:0] sym_buf [MD];
  int mfull = 0, pos = 0, ovf_cnt = 0, drop_cnt = 0, last_cnt = 0;
  bit exp_ovf = 0, exp_drop = 0, gap_chk = 0, chk_en = 0, rr = 0;
  bit pv = 0, pr = 0, pl = 0;
  logic [OW-1:0] pd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [IW-1:0] v);
    return v[IW-1] ? int'(v) - (1 << IW) : int'(v);
  endfunction

  // Outputs are checked mid-cycle; the model then absorbs the inputs/handshake of the coming edge.
  always @(negedge clk) if (chk_en) begin
    int pre, a;
    bit rel, com, act;
    check("banks_full", 64'(banks_full), 64'(mfull));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("addr_drop", 64'(addr_drop), 64'(exp_drop));
    if (overflow === 1'b1) ovf_cnt++;
    if (addr_drop === 1'b1) drop_cnt++;
    if (pv && !pr) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(data_out), 64'(pd));
      check("hold_last", 64'(out_last), 64'(pl));
    end
    if (gap_chk) check("no_gap", 64'(out_valid), 64'(1));
    if (out_valid !== 1'b0) begin
      if (exp_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'(0));
      else begin
        check("data", 64'($signed(data_out)), 64'(exp_q[0]));
        check("last", 64'(out_last), 64'(pos == MD-1));
      end
    end
    pre = mfull; rel = 0; com = 0; gap_chk = 0;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < MD; i++) cur[i] = '0;
      mfull = 0; pos = 0; exp_ovf = 0; exp_drop = 0; pv = 0; pr = 0;
    end else begin
      if (out_valid && ready && exp_q.size() != 0) begin
        sym_buf[pos] = data_out;
        void'(exp_q.pop_front());
        if (pos == MD-1) begin
          rel = 1; pos = 0; last_cnt++;
          gap_chk = (pre > 1);
        end else pos++;
      end
      act = (pre < NB);
      a = int'(waddr) + SH;
      exp_ovf  = (we || sd) && !act;
      exp_drop = we && act && (a >= MD);
      if (we && act && a < MD) cur[a] = din;
      if (sd && act) begin
        for (int i = 0; i < MD; i++) begin
          exp_q.push_back(sx(cur[i]));
          cur[i] = '0;
        end
        com = 1;
      end
      mfull = pre + int'(com) - int'(rel);
      pv = out_valid; pr = ready; pl = out_last; pd = data_out;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rr) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input int addr, input logic [IW-1:0] v);
    we = 1'b1; waddr = 11'(addr); din = v; tick(); we = 1'b0;
  endtask

  task automatic commit();
    sd = 1'b1; tick(); sd = 1'b0; tick();
  endtask

  task automatic rand_sym(input int nwr);
    for (int i = 0; i < nwr; i++) begin
      we = ($urandom_range(0, 3) != 0);
      waddr = 11'($urandom_range(0, MD-1));
      din = IW'($urandom);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < 20000) begin tick(); n++; end
    check("drain_timeout", 64'(n < 20000), 64'(1));
  endtask

  initial begin
    int n, l0, o0, d0;
    tick(); chk_en = 1; tick(); rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_full", 64'(banks_full), 64'(0));
    check("rst_data", 64'(data_out), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_drop", 64'(addr_drop), 64'(0));
    repeat (MD + 20) tick();

    // basic symbol: addr 0..1199 = addr
    ready = 1'b1;
    for (int i = 0; i < 1200; i++) begin we = 1'b1; waddr = 11'(i); din = IW'(i); tick(); end
    we = 1'b0;
    l0 = last_cnt;
    sd = 1'b1; tick(); sd = 1'b0;
    check("lat_c1", 64'(out_valid), 64'(0));
    tick(); check("lat_c2", 64'(out_valid), 64'(0));
    tick(); check("lat_c3", 64'(out_valid), 64'(1));
    drain();
    check("basic_s419", 64'(sym_buf[419]), 64'(0));
    check("basic_s420", 64'(sym_buf[420]), 64'(0));
    check("basic_s421", 64'(sym_buf[421]), 64'(1));
    check("basic_s1619", 64'(sym_buf[1619]), 64'(1199));
    check("basic_s1620", 64'(sym_buf[1620]), 64'(0));
    check("basic_s2047", 64'(sym_buf[2047]), 64'(0));
    check("basic_lasts", 64'(last_cnt - l0), 64'(1));

    // sign extension and range boundaries
    d0 = drop_cnt;
    wr(0, 18'h20001); wr(1, 18'h1FFFF); wr(1627, 18'h00123);
    wr(1628, 18'h3AAAA); wr(1700, 18'h15555);
    tick(); tick();
    check("drop_pulses", 64'(drop_cnt - d0), 64'(2));
    commit(); drain();
    check("sx_neg", 64'(sym_buf[420]), 64'(26'h3FE0001));
    check("sx_pos", 64'(sym_buf[421]), 64'(26'h001FFFF));
    check("edge_2047", 64'(sym_buf[2047]), 64'(26'h0000123));
    check("drop_s0", 64'(sym_buf[0]), 64'(0));

    // overflow with both banks full, then randomized backpressure drain
    ready = 1'b0;
    rand_sym(60); commit();
    rand_sym(60); commit();
    o0 = ovf_cnt;
    sd = 1'b1; tick(); sd = 1'b0; tick(); tick();
    check("ovf_third", 64'(ovf_cnt - o0), 64'(1));
    check("full_two", 64'(banks_full), 64'(2));
    wr(3, 18'h00077); tick();
    rr = 1;
    l0 = last_cnt; n = 0;
    while (last_cnt == l0 && n < 20000) begin tick(); n++; end
    check("first_drain_timeout", 64'(n < 20000), 64'(1));
    rand_sym(80); commit();
    drain();
    rr = 0; ready = 1'b1;

    // reset mid-stream
    rand_sym(100); commit();
    n = 0;
    while (pos < 1000 && n < 5000) begin tick(); n++; end
    check("reach_1000_timeout", 64'(n < 5000), 64'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_full", 64'(banks_full), 64'(0));
    check("mid_rst_last", 64'(out_last), 64'(0));
    repeat (MD + 20) tick();
    rand_sym(100); commit(); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
